// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight's-tour solver sequencer issuing Y/X leg motion commands.
// Optional: TOUR_CMD_FANFARE_EN switches X-leg commands to opcode 4'h3.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       x_start,
    input  logic [2:0]       y_start,
    output logic             busy,
    output logic             tour_done,
    output logic             err,
    output logic             go,
    output logic [2:0]       sol_x,
    output logic [2:0]       sol_y,
    input  logic             done,
    output logic [IDX_W-1:0] indx,
    input  logic [7:0]       move,
    output logic [15:0]      cmd,
    output logic             cmd_vld,
    input  logic             cmd_rdy
);

    typedef enum logic [2:0] {IDLE, KICK, WAIT, FETCH, LEG_Y, LEG_X} state_t;

    localparam logic [3:0] OP_MOVE = 4'h2;
`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] OP_X = 4'h3;
`else
    localparam logic [3:0] OP_X = OP_MOVE;
`endif
    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t           state_q, state_d;
    logic             go_q, go_d;
    logic             tour_done_q, tour_done_d;
    logic             err_q, err_d;
    logic             cmd_vld_q, cmd_vld_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [IDX_W-1:0] indx_q, indx_d;
    logic [2:0]       sol_x_q, sol_x_d;
    logic [2:0]       sol_y_q, sol_y_d;
    logic             x_neg_q, x_neg_d;
    logic             x_two_q, x_two_d;

    logic move_ok, dx_neg, dx_two, dy_neg, dy_two;

    // Anything other than a single set bit falls into default and is rejected.
    always_comb begin
        move_ok = 1'b1;
        dx_neg  = 1'b0;
        dx_two  = 1'b0;
        dy_neg  = 1'b0;
        dy_two  = 1'b0;
        case (move)
            8'h01: begin                                   dy_two = 1'b1; end
            8'h02: begin dx_neg = 1'b1;                    dy_two = 1'b1; end
            8'h04: begin dx_neg = 1'b1; dx_two = 1'b1;                    end
            8'h08: begin dx_neg = 1'b1; dx_two = 1'b1; dy_neg = 1'b1;     end
            8'h10: begin dx_neg = 1'b1; dy_neg = 1'b1; dy_two = 1'b1;     end
            8'h20: begin                dy_neg = 1'b1; dy_two = 1'b1;     end
            8'h40: begin dx_two = 1'b1; dy_neg = 1'b1;                    end
            8'h80: begin dx_two = 1'b1;                                   end
            default: move_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        go_d        = 1'b0;
        tour_done_d = 1'b0;
        err_d       = 1'b0;
        cmd_vld_d   = cmd_vld_q;
        cmd_d       = cmd_q;
        indx_d      = indx_q;
        sol_x_d     = sol_x_q;
        sol_y_d     = sol_y_q;
        x_neg_d     = x_neg_q;
        x_two_d     = x_two_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sol_x_d = x_start;
                    sol_y_d = y_start;
                    indx_d  = '0;
                    go_d    = 1'b1;
                    state_d = KICK;
                end
            end
            KICK: state_d = WAIT;
            WAIT: if (done) state_d = FETCH;
            FETCH: begin
                if (!move_ok) begin
                    err_d     = 1'b1;
                    cmd_vld_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    x_neg_d   = dx_neg;
                    x_two_d   = dx_two;
                    cmd_d     = {OP_MOVE, dy_neg ? HEAD_S : HEAD_N, dy_two ? 4'd2 : 4'd1};
                    cmd_vld_d = 1'b1;
                    state_d   = LEG_Y;
                end
            end
            LEG_Y: begin
                // X leg follows immediately; cmd_vld stays high across the swap.
                if (cmd_rdy) begin
                    cmd_d   = {OP_X, x_neg_q ? HEAD_W : HEAD_E, x_two_q ? 4'd2 : 4'd1};
                    state_d = LEG_X;
                end
            end
            LEG_X: begin
                if (cmd_rdy) begin
                    cmd_vld_d = 1'b0;
                    if (indx_q == LAST_IDX) begin
                        tour_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        indx_d  = indx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            go_q        <= 1'b0;
            tour_done_q <= 1'b0;
            err_q       <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_q       <= '0;
            indx_q      <= '0;
            sol_x_q     <= '0;
            sol_y_q     <= '0;
            x_neg_q     <= 1'b0;
            x_two_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            tour_done_q <= tour_done_d;
            err_q       <= err_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_q       <= cmd_d;
            indx_q      <= indx_d;
            sol_x_q     <= sol_x_d;
            sol_y_q     <= sol_y_d;
            x_neg_q     <= x_neg_d;
            x_two_q     <= x_two_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign go        = go_q;
    assign tour_done = tour_done_q;
    assign err       = err_q;
    assign cmd_vld   = cmd_vld_q;
    assign cmd       = cmd_q;
    assign indx      = indx_q;
    assign sol_x     = sol_x_q;
    assign sol_y     = sol_y_q;

endmodule
